// File: rtl/pkt_proc_deq_reader.sv
// Dequeue-side master: issues deq_req against guaranteed buffer space, frames the
// returned beats into packets and presents them on a valid/ready stream.
module pkt_proc_deq_reader #(
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 4,
  parameter int LEN_W     = 12,
  parameter int CNT_W     = 16
) (
  input  logic              pck_proc_int_mem_fsm_clk,
  input  logic              pck_proc_int_mem_fsm_rst,
  input  logic              deq_en,
  input  logic              pck_proc_empty,
  output logic              deq_req,
  input  logic              out_sop,
  input  logic [DATA_W-1:0] rd_data_o,
  input  logic              out_eop,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sop,
  output logic              m_eop,
  output logic [LEN_W-1:0]  m_len,
  output logic              err_missing_sop,
  output logic              err_missing_eop,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);
  localparam int AW    = $clog2(BUF_DEPTH);
  localparam int OCC_W = AW + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic [LEN_W-1:0]  len;
  } ent_t;

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  logic             clk, rst;
  state_t           state;
  logic [LEN_W-1:0] count, cnt_nxt;
  logic             inflight;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ;
  ent_t             mem [BUF_DEPTH];
  ent_t             ent_w, head;
  logic             push, drop, pop;

  assign clk = pck_proc_int_mem_fsm_clk;
  assign rst = pck_proc_int_mem_fsm_rst;

  // Occupancy plus the beat already in flight must leave room, so a push never hits a full buffer.
  assign deq_req = ~rst & deq_en & ~pck_proc_empty &
                   (({1'b0, occ} + (OCC_W+1)'(inflight)) < (OCC_W+1)'(BUF_DEPTH));

  assign push = inflight & (out_sop | (state == IN_PKT));
  assign drop = inflight & ~out_sop & (state == IDLE);
  assign pop  = m_valid & m_ready;

  always_comb begin
    cnt_nxt = LEN_W'(1);
    if (!out_sop && state == IN_PKT)
      cnt_nxt = (count == '1) ? count : count + LEN_W'(1);
  end

  assign ent_w = '{data: rd_data_o, sop: out_sop, eop: out_eop, len: cnt_nxt};
  assign head  = mem[rd_ptr];

  assign m_valid = (occ != '0);
  assign m_data  = head.data;
  assign m_sop   = head.sop;
  assign m_eop   = head.eop;
  assign m_len   = head.len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      count           <= '0;
      inflight        <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      occ             <= '0;
      err_missing_sop <= 1'b0;
      err_missing_eop <= 1'b0;
      pkt_cnt         <= '0;
      drop_cnt        <= '0;
    end else begin
      inflight        <= deq_req;
      err_missing_sop <= drop;
      err_missing_eop <= inflight & out_sop & (state == IN_PKT);
      if (push) begin
        count  <= cnt_nxt;
        wr_ptr <= wr_ptr + AW'(1);
        state  <= out_eop ? IDLE : IN_PKT;
        if (out_eop && pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_W'(1);
      end
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
  end

  // Storage is cleared on reset so the stream outputs read back as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= ent_w;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && occ == OCC_W'(BUF_DEPTH)))
      else $error("push into full output buffer");
  end
`endif
endmodule

// File: tb/tb_pkt_proc_deq_reader.sv
// Randomized bench: processor model with 1-cycle read latency, framing reference
// model and output scoreboard for pkt_proc_deq_reader.
module tb_pkt_proc_deq_reader;
  localparam int DW = 32, BD = 4, LW = 3, CW = 5;
  localparam int LMAX = (1 << LW) - 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 0, rst = 1;
  logic          deq_en = 0, pck_proc_empty = 1, deq_req;
  logic          out_sop = 0, out_eop = 0;
  logic [DW-1:0] rd_data_o = '0;
  logic          m_valid, m_ready = 0, m_sop, m_eop;
  logic [DW-1:0] m_data;
  logic [LW-1:0] m_len;
  logic          err_missing_sop, err_missing_eop;
  logic [CW-1:0] pkt_cnt, drop_cnt;

  pkt_proc_deq_reader #(.DATA_W(DW), .BUF_DEPTH(BD), .LEN_W(LW), .CNT_W(CW)) dut (
    .pck_proc_int_mem_fsm_clk(clk), .pck_proc_int_mem_fsm_rst(rst),
    .deq_en(deq_en), .pck_proc_empty(pck_proc_empty), .deq_req(deq_req),
    .out_sop(out_sop), .rd_data_o(rd_data_o), .out_eop(out_eop),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sop(m_sop),
    .m_eop(m_eop), .m_len(m_len), .err_missing_sop(err_missing_sop),
    .err_missing_eop(err_missing_eop), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  typedef struct { bit sop; bit eop; logic [DW-1:0] d; } beat_t;
  typedef struct { logic [DW-1:0] d; bit sop; bit eop; int len; } oexp_t;

  beat_t src_q[$];
  oexp_t exp_q[$];
  beat_t cur;
  bit    cur_v, rst_pending = 1, req_prev, force_empty, gen_in;
  bit    m_in_pkt, e_esop, e_eeop;
  int    m_cnt, e_pkt, e_drop;
  bit    knob_rand, knob_en, knob_ready, knob_toggle;
  int    checks, fails, issued, popped, run, maxrun;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_in_pkt = 0; m_cnt = 0; e_pkt = 0; e_drop = 0; cur_v = 0;
  endfunction

  function automatic void emit(beat_t b, bit first);
    oexp_t o;
    o.d = b.d; o.sop = first; o.eop = b.eop; o.len = m_cnt;
    exp_q.push_back(o);
    if (b.eop) begin
      m_in_pkt = 0;
      if (e_pkt < CMAX) e_pkt++;
    end else m_in_pkt = 1;
  endfunction

  // Framing rules applied to one captured beat
  function automatic void process(beat_t b);
    if (b.sop) begin
      if (m_in_pkt) e_eeop = 1;
      m_cnt = 1;
      emit(b, 1);
    end else if (m_in_pkt) begin
      if (m_cnt < LMAX) m_cnt++;
      emit(b, 0);
    end else begin
      e_esop = 1;
      if (e_drop < CMAX) e_drop++;
    end
  endfunction

  function automatic void gen_beats(int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.sop = gen_in ? ($urandom % 12 == 0) : ($urandom % 10 != 0);
      b.eop = ($urandom % 4 == 0);
      b.d   = $urandom;
      if (b.sop) gen_in = 1;
      if (b.eop) gen_in = 0;
      src_q.push_back(b);
    end
  endfunction

  function automatic void add(bit s, bit e, logic [DW-1:0] d);
    beat_t b;
    b.sop = s; b.eop = e; b.d = d;
    src_q.push_back(b);
  endfunction

  task automatic step(input bit rst_i);
    bit    exp_req;
    oexp_t o;
    @(posedge clk); #1;
    e_esop = 0; e_eeop = 0;
    if (rst_pending) model_reset();
    else if (cur_v) process(cur);
    rst = rst_i; rst_pending = rst_i;
    if (req_prev && src_q.size() > 0) begin
      cur = src_q.pop_front(); cur_v = 1;
    end else begin
      cur_v = 0; cur.sop = 1'($urandom); cur.eop = 1'($urandom); cur.d = $urandom;
    end
    out_sop = cur.sop; out_eop = cur.eop; rd_data_o = cur.d;
    if (knob_rand) begin
      deq_en = ($urandom % 10) != 0;
      m_ready = ($urandom % 10) < 7;
      force_empty = ($urandom % 5) == 0;
    end else begin
      deq_en = knob_en; m_ready = knob_ready;
      force_empty = knob_toggle ? ~force_empty : 1'b0;
    end
    pck_proc_empty = force_empty || src_q.size() == 0;
    @(negedge clk);
    exp_req = !rst && deq_en && !pck_proc_empty && (exp_q.size() + int'(cur_v) < BD);
    chk("deq_req", deq_req, exp_req);
    chk("m_valid", m_valid, exp_q.size() != 0);
    chk("err_sop", err_missing_sop, e_esop);
    chk("err_eop", err_missing_eop, e_eeop);
    chk("pkt_cnt", pkt_cnt, e_pkt);
    chk("drop_cnt", drop_cnt, e_drop);
    req_prev = deq_req;
    if (deq_req) begin issued++; run++; end else run = 0;
    if (run > maxrun) maxrun = run;
    if (m_valid && m_ready && exp_q.size() > 0) begin
      o = exp_q.pop_front();
      popped++;
      chk("m_data", m_data, o.d);
      chk("m_sop", m_sop, o.sop);
      chk("m_eop", m_eop, o.eop);
      if (o.eop) chk("m_len", m_len, o.len);
    end
  endtask

  task automatic do_reset();
    knob_rand = 0; knob_en = 0; knob_ready = 0; knob_toggle = 0;
    src_q.delete(); gen_in = 0;
    step(1); step(1); step(0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_len", m_len, 0);
    issued = 0; popped = 0; run = 0; maxrun = 0;
  endtask

  initial begin
    // 4-word packet at full rate
    do_reset();
    knob_en = 1; knob_ready = 1;
    for (int i = 0; i < 4; i++) add(i == 0, i == 3, 32'hA0 + i);
    for (int i = 0; i < 10; i++) step(0);
    chk("run4", maxrun, 4);
    chk("pkt1", pkt_cnt, 1);

    // single-word packet
    add(1, 1, 32'h55);
    for (int i = 0; i < 6; i++) step(0);
    chk("pkt2", pkt_cnt, 2);

    // backpressure with a 10-word packet; length saturates
    do_reset();
    knob_en = 1; knob_ready = 0;
    for (int i = 0; i < 10; i++) add(i == 0, i == 9, 32'hB0 + i);
    for (int i = 0; i < 10; i++) step(0);
    chk("bp_issued", issued, BD);
    chk("bp_full", m_valid, 1);
    knob_ready = 1;
    for (int i = 0; i < 25; i++) step(0);
    chk("bp_drained", popped, 10);

    // framing errors
    do_reset();
    knob_en = 1; knob_ready = 1;
    add(0, 0, 32'h11); add(1, 0, 32'h21); add(0, 0, 32'h22);
    add(1, 0, 32'h31); add(0, 1, 32'h32);
    for (int i = 0; i < 12; i++) step(0);
    chk("fr_drop", drop_cnt, 1);
    chk("fr_pkt", pkt_cnt, 1);

    // empty toggling every cycle
    knob_toggle = 1;
    for (int i = 0; i < 8; i++) add(i == 0, i == 7, 32'hC0 + i);
    for (int i = 0; i < 24; i++) step(0);
    knob_toggle = 0;

    // reset while a beat is in flight
    do_reset();
    knob_en = 1; knob_ready = 1;
    add(1, 0, 32'hD0); add(0, 0, 32'hD1); add(0, 1, 32'hD2);
    begin
      int n = 0;
      while (!req_prev && n < 10) begin step(0); n++; end
      chk("rst_req_seen", req_prev, 1);
    end
    knob_en = 0;
    step(1);
    step(0);
    chk("rst_pkt", pkt_cnt, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    knob_en = 1;
    for (int i = 0; i < 8; i++) step(0);
    add(1, 0, 32'hE0); add(0, 1, 32'hE1);
    for (int i = 0; i < 8; i++) step(0);
    chk("rst_after_pkt", pkt_cnt, 1);

    // random traffic with framing errors and mid-run resets
    do_reset();
    knob_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      if (src_q.size() < 4) gen_beats(8);
      step(i % 997 == 500);
    end
    chk("rand_cnt_sat", pkt_cnt, CMAX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
